memref_port_arbiter: RTL

- Shares one physical memref port (addr/rd/wr, fixed read latency) among NREQ kernel-side requesters.
- Typical use: HIR and HLS kernels with more logical accesses to one buffer (e.g. tmp, D) than the BRAM has ports.
- Grants one access per cycle using round-robin priority.
- Tags each issued read and routes the returned data, with a valid strobe, back to the issuing requester.

---
 rtl/memref_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/memref_port_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/memref_arb_pkg.sv
// Shared types and helpers for the memref port arbiter: tag width, read-return tag, request vector.
package memref_arb_pkg;

    localparam int MAX_NREQ  = 8;
    localparam int TAG_MAX_W = 3;

    // Index width for NREQ requesters, never narrower than one bit.
    function automatic int tag_w(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] idx;
    } rd_tag_t;

    typedef logic [MAX_NREQ-1:0] req_vec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping modulo NREQ.
module rr_arbiter
    import memref_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = tag_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [TAG_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [TAG_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int pos;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            // Inner compare keeps every req/gnt select at a constant index.
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_any && (j == pos) && req[j]) begin
                    gnt[j]  = 1'b1;
                    gnt_idx = TAG_W'(j);
                    gnt_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/memref_port_arbiter.sv
// Shares one fixed-latency memref port among NREQ requesters with round-robin grants
// and routes each read return back to its issuer through a tag pipeline.
module memref_port_arbiter
    import memref_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6,
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_rd_en,
    input  logic [NREQ-1:0]        req_wr_en,
    input  logic [NREQ*ADDR_W-1:0] req_addr_data,
    input  logic [NREQ*WIDTH-1:0]  req_wr_data,
    output logic [NREQ-1:0]        req_gnt,
    output logic [NREQ-1:0]        req_rd_valid,
    output logic [WIDTH-1:0]       req_rd_data,
    output logic                   mem_addr_en,
    output logic [ADDR_W-1:0]      mem_addr_data,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [WIDTH-1:0]       mem_wr_data,
    input  logic [WIDTH-1:0]       mem_rd_data,
    output logic                   err_rdwr
);

    localparam int TAG_W = tag_w(NREQ);

    logic [NREQ-1:0]  active;
    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             gnt_rd;
    logic             gnt_wr;
    rd_tag_t          rd_tag_p [RD_LAT];

    // Requests are masked during reset so every output reads 0 there.
    assign active = (req_rd_en | req_wr_en) & {NREQ{rst}};

    rr_arbiter #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) u_rr_arbiter (
        .req     (active),
        .ptr     (ptr),
        .gnt     (req_gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        gnt_rd        = 1'b0;
        gnt_wr        = 1'b0;
        mem_addr_data = '0;
        mem_wr_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_gnt[i]) begin
                gnt_rd        = req_rd_en[i];
                gnt_wr        = req_wr_en[i];
                mem_addr_data = req_addr_data[i*ADDR_W +: ADDR_W];
                mem_wr_data   = req_wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A requester raising both enables gets its write; the read is dropped.
    assign mem_addr_en = gnt_any;
    assign mem_wr_en   = gnt_wr;
    assign mem_rd_en   = gnt_rd & ~gnt_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_rdwr <= 1'b0;
        end else begin
            err_rdwr <= err_rdwr | (|(req_rd_en & req_wr_en));
        end
    end

    // Stage 0 captures the issued read; later stages shift it toward the return point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                rd_tag_p[k] <= '0;
            end
        end else begin
            rd_tag_p[0] <= '{valid: mem_rd_en, idx: TAG_MAX_W'(gnt_idx)};
            for (int k = 1; k < RD_LAT; k++) begin
                rd_tag_p[k] <= rd_tag_p[k-1];
            end
        end
    end

    // Last stage lines up with mem_rd_data.
    always_comb begin
        req_rd_valid = '0;
        req_rd_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_tag_p[RD_LAT-1].valid && (int'(rd_tag_p[RD_LAT-1].idx) == i)) begin
                req_rd_valid[i] = 1'b1;
            end
        end
        if (rd_tag_p[RD_LAT-1].valid) begin
            req_rd_data = mem_rd_data;
        end
    end

endmodule
